// File: rtl/irq_vector_arbiter.sv
// Priority arbiter and 68000 interrupt-acknowledge responder with a small register file.
// ipl_n lags pending by one cycle; vector strobes appear two cycles after IACK and are held until cpu_as falls.
module irq_vector_arbiter #(
   parameter int          NUM_SRC      = 8,
   parameter logic [7:0]  VEC_BASE_RST = 8'h40,
   parameter logic [7:0]  SPURIOUS_VEC = 8'h18
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [15:0]        data_write,
   output logic [15:0]        data_read,
   input  logic [7:0]         addr,
   input  logic               uds,
   input  logic               lds,
   input  logic               rw,
   input  logic               as,
   output logic               ack,
   input  logic [NUM_SRC-1:0] irq_pending,
   input  logic [2:0]         fc,
   input  logic               cpu_as,
   input  logic [2:0]         iack_level,
   output logic [2:0]         ipl_n,
   output logic               iack_dtack,
   output logic               iack_vpa,
   output logic [7:0]         vector_out,
   output logic [NUM_SRC-1:0] iack_clear
);

   typedef enum logic [1:0] {IDLE, SELECT, PRESENT, RELEASE} state_t;

   state_t       state_q, state_d;
   logic         arb_enable_q, autovec_q;
   logic [7:0]   vbase_q;
   logic [2:0]   level_q [NUM_SRC];
   logic [2:0]   last_src_q;
   logic         last_spur_q;
   logic [2:0]   req_lvl_q;
   logic         ack_q;
   logic [15:0]  rd_q;
   logic [2:0]   ipl_q;
   logic         dtack_q, vpa_q;
   logic [7:0]   vec_q;

   logic               wr_lo;
   logic [7:0]         rd_byte;
   logic [NUM_SRC-1:0] lvl_wr;
   logic [2:0]         win_level;
   logic               sel_found;
   logic [2:0]         sel_idx;
   logic               unused_bits;

   // Every register lives in the low byte lane; the upper lane is accepted but inert.
   assign unused_bits = ^{uds, data_write[15:8]};
   assign wr_lo       = as && !rw && lds;

   always_comb begin
      rd_byte = '0;
      lvl_wr  = '0;
      case (addr)
         8'h02:   rd_byte = {6'b0, autovec_q, arb_enable_q};
         8'h06:   rd_byte = vbase_q;
         8'h0A:   rd_byte = {last_spur_q, last_src_q, 1'b0, ~ipl_q};
         default: rd_byte = '0;
      endcase
      for (int i = 0; i < NUM_SRC; i++) begin
         if (addr == 8'(16 + 2 * i)) begin
            rd_byte   = {5'b0, level_q[i]};
            lvl_wr[i] = wr_lo;
         end
      end
   end

   always_comb begin
      win_level = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (irq_pending[i] && (level_q[i] != 3'd0) && (level_q[i] > win_level))
            win_level = level_q[i];
      end
      if (!arb_enable_q)
         win_level = '0;
   end

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (irq_pending[i] && (level_q[i] != 3'd0) && (level_q[i] == req_lvl_q)) begin
            sel_found = 1'b1;
            sel_idx   = 3'(i);
         end
      end
      if (!arb_enable_q)
         sel_found = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fc == 3'b111 && cpu_as) state_d = SELECT;
         SELECT:  state_d = PRESENT;
         PRESENT: state_d = RELEASE;
         RELEASE: if (!cpu_as) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         arb_enable_q <= 1'b0;
         autovec_q    <= 1'b0;
         vbase_q      <= VEC_BASE_RST;
         for (int i = 0; i < NUM_SRC; i++)
            level_q[i] <= '0;
         last_src_q   <= '0;
         last_spur_q  <= 1'b0;
         req_lvl_q    <= '0;
         ack_q        <= 1'b0;
         rd_q         <= '0;
         ipl_q        <= 3'b111;
         dtack_q      <= 1'b0;
         vpa_q        <= 1'b0;
         vec_q        <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= as;
         rd_q    <= (as && rw && lds) ? {8'h00, rd_byte} : 16'h0000;

         if (wr_lo && addr == 8'h02) begin
            arb_enable_q <= data_write[0];
            autovec_q    <= data_write[1];
         end
         if (wr_lo && addr == 8'h06)
            vbase_q <= data_write[7:0];
         for (int i = 0; i < NUM_SRC; i++) begin
            if (lvl_wr[i])
               level_q[i] <= data_write[2:0];
         end

         case (state_q)
            IDLE: begin
               ipl_q <= ~win_level;
               if (state_d == SELECT)
                  req_lvl_q <= iack_level;
            end
            SELECT: begin
               if (sel_found) begin
                  vec_q       <= vbase_q + {5'b0, sel_idx};
                  last_src_q  <= sel_idx;
                  last_spur_q <= 1'b0;
                  vpa_q       <= autovec_q;
                  dtack_q     <= !autovec_q;
               end else begin
                  vec_q       <= SPURIOUS_VEC;
                  last_spur_q <= 1'b1;
                  dtack_q     <= 1'b1;
               end
            end
            RELEASE: begin
               if (!cpu_as) begin
                  dtack_q <= 1'b0;
                  vpa_q   <= 1'b0;
                  vec_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // The clear pulse is combinational so it reflects pending as seen in SELECT itself.
   assign iack_clear = (reset_n && state_q == SELECT && sel_found)
                       ? (NUM_SRC'(1) << sel_idx) : '0;

   assign ack        = ack_q;
   assign data_read  = rd_q;
   assign ipl_n      = ipl_q;
   assign iack_dtack = dtack_q;
   assign iack_vpa   = vpa_q;
   assign vector_out = vec_q;

endmodule

// File: tb/tb_irq_vector_arbiter.sv
// Scoreboard bench for irq_vector_arbiter: stimulus queues expectations, a negedge monitor retires them.
module tb_irq_vector_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] data_write, data_read;
   logic [7:0]  addr;
   logic        uds, lds, rw, as, ack;
   logic [7:0]  irq_pending;
   logic [2:0]  fc, iack_level, ipl_n;
   logic        cpu_as, iack_dtack, iack_vpa;
   logic [7:0]  vector_out, iack_clear;

   always #5 clk = ~clk;

   irq_vector_arbiter dut (
      .clk(clk), .reset_n(reset_n), .data_write(data_write), .data_read(data_read),
      .addr(addr), .uds(uds), .lds(lds), .rw(rw), .as(as), .ack(ack),
      .irq_pending(irq_pending), .fc(fc), .cpu_as(cpu_as), .iack_level(iack_level),
      .ipl_n(ipl_n), .iack_dtack(iack_dtack), .iack_vpa(iack_vpa),
      .vector_out(vector_out), .iack_clear(iack_clear)
   );

   typedef struct { logic [15:0] dat; int c; } rd_exp_t;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int iack_cyc = 0;
   rd_exp_t    rd_exp_q[$];
   logic [9:0] vec_exp_q[$];
   logic [7:0] clr_exp_q[$];
   rd_exp_t    rd_e;
   logic [9:0] vec_e;
   logic [7:0] clr_e;
   logic       prev_strobe = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (ack) begin
         if (rd_exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
         else begin
            rd_e = rd_exp_q.pop_front();
            chk("read_data", 32'(data_read), 32'(rd_e.dat));
            chk("ack_latency", 32'(cyc - rd_e.c), 32'd1);
         end
      end else begin
         chk("read_idle_zero", 32'(data_read), 32'd0);
      end
      if (iack_clear != 8'h00) begin
         if (clr_exp_q.size() == 0) chk("unexpected_clear", 32'(iack_clear), 32'd0);
         else begin
            clr_e = clr_exp_q.pop_front();
            chk("iack_clear", 32'(iack_clear), 32'(clr_e));
            chk("clear_latency", 32'(cyc - iack_cyc), 32'd1);
         end
      end
      if ((iack_dtack || iack_vpa) && !prev_strobe) begin
         if (vec_exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
         else begin
            vec_e = vec_exp_q.pop_front();
            chk("dtack_vpa_vector", 32'({iack_dtack, iack_vpa, vector_out}), 32'(vec_e));
            chk("strobe_latency", 32'(cyc - iack_cyc), 32'd2);
         end
      end
      prev_strobe <= iack_dtack || iack_vpa;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [15:0] d, input logic lo);
      rd_exp_q.push_back('{dat: 16'h0000, c: cyc});
      as = 1'b1; rw = 1'b0; addr = a; data_write = d; lds = lo; uds = !lo;
      tick();
      as = 1'b0; lds = 1'b0; uds = 1'b0;
   endtask

   task automatic reg_rd(input logic [7:0] a, input logic [15:0] exp);
      rd_exp_q.push_back('{dat: exp, c: cyc});
      as = 1'b1; rw = 1'b1; addr = a; lds = 1'b1; uds = 1'b0;
      tick();
      as = 1'b0; lds = 1'b0; rw = 1'b0;
   endtask

   task automatic start_iack(input logic [2:0] lvl, input logic [7:0] clr,
                             input logic dt, input logic vp, input logic [7:0] vec);
      vec_exp_q.push_back({dt, vp, vec});
      if (clr != 8'h00) clr_exp_q.push_back(clr);
      fc = 3'b111; cpu_as = 1'b1; iack_level = lvl; iack_cyc = cyc;
      repeat (4) tick();
      chk("strobe_held", 32'({iack_dtack, iack_vpa}), 32'({dt, vp}));
   endtask

   task automatic iack(input logic [2:0] lvl, input logic [7:0] clr,
                       input logic dt, input logic vp, input logic [7:0] vec);
      start_iack(lvl, clr, dt, vp, vec);
      cpu_as = 1'b0; fc = 3'b000;
      tick();
      chk("release_clears", 32'({iack_dtack, iack_vpa, vector_out}), 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; data_write = '0; addr = '0; uds = 0; lds = 0; rw = 0; as = 0;
      irq_pending = '0; fc = '0; cpu_as = 0; iack_level = '0;
      repeat (3) tick();
      chk("rst_outputs", 32'({ipl_n, ack, iack_dtack, iack_vpa, vector_out, iack_clear}),
          32'({3'b111, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
      reset_n = 1'b1;
      tick();
      reg_rd(8'h02, 16'h0000);
      reg_rd(8'h06, 16'h0040);
      reg_rd(8'h0A, 16'h0000);

      // Priority encoding and one-cycle ipl latency
      reg_wr(8'h10, 16'h0002, 1'b1);
      reg_wr(8'h14, 16'h0005, 1'b1);
      reg_wr(8'h02, 16'h0001, 1'b1);
      irq_pending = 8'b101;
      chk("ipl_before", 32'(ipl_n), 32'(3'b111));
      tick();
      chk("ipl_lvl5", 32'(ipl_n), 32'(3'b010));
      irq_pending = 8'b001;
      tick();
      chk("ipl_lvl2", 32'(ipl_n), 32'(3'b101));

      // Basic vectored acknowledge
      reg_wr(8'h10, 16'h0000, 1'b1);
      reg_wr(8'h14, 16'h0000, 1'b1);
      reg_wr(8'h16, 16'h0004, 1'b1);
      irq_pending = 8'h08;
      iack(3'd4, 8'h08, 1'b1, 1'b0, 8'h43);
      reg_rd(8'h0A, 16'h0034);

      // Equal levels: lowest index wins
      reg_wr(8'h16, 16'h0000, 1'b1);
      reg_wr(8'h12, 16'h0003, 1'b1);
      reg_wr(8'h18, 16'h0003, 1'b1);
      irq_pending = 8'h12;
      iack(3'd3, 8'h02, 1'b1, 1'b0, 8'h41);
      irq_pending = 8'h10;
      iack(3'd3, 8'h10, 1'b1, 1'b0, 8'h44);
      reg_rd(8'h0A, 16'h0043);

      // Autovector, then spurious level
      reg_wr(8'h02, 16'h0003, 1'b1);
      iack(3'd3, 8'h10, 1'b0, 1'b1, 8'h44);
      iack(3'd6, 8'h00, 1'b1, 1'b0, 8'h18);
      reg_rd(8'h0A, 16'h00C3);
      reg_wr(8'h0A, 16'h00FF, 1'b1);
      reg_rd(8'h0A, 16'h00C3);

      // Arbitration disabled: no level, spurious acknowledge; uds-only write is inert
      reg_wr(8'h02, 16'h0000, 1'b1);
      tick();
      chk("ipl_disabled", 32'(ipl_n), 32'(3'b111));
      iack(3'd3, 8'h00, 1'b1, 1'b0, 8'h18);
      reg_wr(8'h02, 16'h0303, 1'b0);
      reg_rd(8'h02, 16'h0000);
      reg_rd(8'h40, 16'h0000);

      // Vector wraps modulo 256
      reg_wr(8'h02, 16'h0001, 1'b1);
      reg_wr(8'h06, 16'h00FE, 1'b1);
      reg_wr(8'h16, 16'h0004, 1'b1);
      irq_pending = 8'h08;
      iack(3'd4, 8'h08, 1'b1, 1'b0, 8'h01);
      reg_rd(8'h0A, 16'h0034);

      // Reset during RELEASE
      start_iack(3'd4, 8'h08, 1'b1, 1'b0, 8'h01);
      reset_n = 1'b0; cpu_as = 1'b0; fc = 3'b000;
      tick();
      chk("rst_mid_strobes", 32'({iack_dtack, iack_vpa, vector_out}), 32'd0);
      chk("rst_mid_ipl", 32'(ipl_n), 32'(3'b111));
      reset_n = 1'b1;
      tick();
      chk("ipl_after_rst", 32'(ipl_n), 32'(3'b111));
      reg_rd(8'h02, 16'h0000);
      reg_rd(8'h06, 16'h0040);
      reg_wr(8'h14, 16'h0007, 1'b1);
      reg_rd(8'h14, 16'h0007);

      repeat (4) tick();
      chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
      chk("vec_queue_drained", 32'(vec_exp_q.size()), 32'd0);
      chk("clr_queue_drained", 32'(clr_exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/irq_vector_arbiter.md
Name: irq_vector_arbiter

Overview:
Sits between the interrupt controller's masked pending vector and the 68000 core. It assigns each interrupt source a programmable priority level (1..7), drives ipl_n with the highest pending level, and services the CPU interrupt-acknowledge cycle. In that cycle it selects the winning source, returns either a vector number or an autovector request, and pulses a per-source clear back to the interrupt controller.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..8).
VEC_BASE_RST, 8'h40, reset value of the vector base register.
SPURIOUS_VEC, 8'h18, vector returned when no source matches the acknowledged level.

Ports:
clk  in  1  system clock.
reset_n  in  1  synchronous, active-low reset.
data_write  in  16  register write data.
data_read  out  16  register read data; 0 when no read is in progress.
addr  in  8  register byte address.
uds  in  1  upper byte strobe, active-high.
lds  in  1  lower byte strobe, active-high.
rw  in  1  1 = read, 0 = write.
as  in  1  register-space select, active-high, already qualified by the address decoder.
ack  out  1  register access acknowledge.
irq_pending  in  NUM_SRC  pending and enabled sources from the interrupt controller, level-sensitive.
fc  in  3  CPU function code.
cpu_as  in  1  CPU address strobe, active-high.
iack_level  in  3  CPU A3..A1 during the acknowledge cycle.
ipl_n  out  3  interrupt priority level to the CPU, active-low.
iack_dtack  out  1  vector valid on vector_out.
iack_vpa  out  1  autovector request.
vector_out  out  8  vector number.
iack_clear  out  NUM_SRC  one-cycle pulse clearing the acknowledged source.

Behaviour:
- Register map (word addresses, byte-lane strobes):
  - 0x02, lds: CTRL. bit0 = arb_enable, bit1 = autovec_mode. RW.
  - 0x06, lds: VBASE[7:0]. RW.
  - 0x0A, lds: STATUS. [2:0] = current arbitrated level, [6:4] = last acknowledged source index, [7] = last acknowledge was spurious. Read-only; writes are ignored.
  - 0x10 + 2*i, lds: LEVEL[i][2:0] for source i. RW. Level 0 masks the source.
  - All other addresses: ack is asserted; reads return 0; writes have no effect.
- Register access timing:
  - Any cycle with as=1 gives a registered ack=1 on the next cycle.
  - data_read is registered with the same one-cycle latency, and is 0 on every other cycle.
  - uds-only accesses are acknowledged with no effect.
- Reset values: CTRL=0, VBASE=VEC_BASE_RST, every LEVEL=0, STATUS=0, ipl_n=3'b111, ack=0, iack_dtack=0, iack_vpa=0, vector_out=0, iack_clear=0.
- Arbitration (every cycle, state IDLE):
  - win_level = max LEVEL[i] over all i with irq_pending[i]=1 and LEVEL[i]≠0.
  - If there is no candidate, or arb_enable=0, win_level=0.
  - ipl_n is registered as ~win_level, i.e. one cycle of latency.
  - ipl_n is frozen outside IDLE.
- State machine IDLE → SELECT → PRESENT → RELEASE → IDLE.
  - IDLE: fc=3'b111 and cpu_as=1 → SELECT. Latch iack_level into req_lvl.
  - SELECT (one cycle): pick the lowest index i with irq_pending[i]=1 and LEVEL[i]==req_lvl.
    - If found: vector_out = VBASE + i (8-bit, wraps modulo 256). Pulse iack_clear[i] for exactly one cycle. Update STATUS[6:4]=i and STATUS[7]=0.
    - If not found, or arb_enable=0: vector_out = SPURIOUS_VEC and STATUS[7]=1.
  - PRESENT:
    - Found and autovec_mode=1: assert iack_vpa.
    - Otherwise: assert iack_dtack (the spurious case always uses dtack).
    - Go to RELEASE.
  - RELEASE: hold iack_dtack/iack_vpa and vector_out until cpu_as=0. Then deassert both strobes, clear vector_out to 0, and return to IDLE.
- Latency: IACK is seen in cycle N; iack_dtack or iack_vpa is asserted from cycle N+2.
- Simultaneous events:
  - A register write in the same cycle as IACK detection takes effect, and SELECT uses the new value.
  - A source that deasserts irq_pending between IDLE and SELECT is not chosen.
- Reset mid-operation: the next clk edge returns to IDLE with every output at its reset value, and no iack_clear pulse is issued.
- cpu_as already low when PRESENT is entered: RELEASE lasts one cycle, then IDLE.

Test Plan:
1. LEVEL[0]=2, LEVEL[2]=5, CTRL=1, irq_pending=8'b101 → ipl_n=3'b010 one cycle later. With pending=8'b001 → ipl_n=3'b101.
2. VBASE=0x40, LEVEL[3]=4, pending bit 3, IACK with iack_level=4 → iack_clear=8'h08 for one cycle at N+1; iack_dtack=1 and vector_out=0x43 from N+2 until cpu_as falls; STATUS reads 0x34.
3. LEVEL[1]=LEVEL[4]=3, both pending, IACK level 3 → source 1 wins, vector VBASE+1; repeat after clearing source 1 → source 4 wins.
4. autovec_mode=1, IACK of a matching source → iack_vpa=1, iack_dtack=0. IACK level 6 with no level-6 source → iack_dtack=1, vector_out=0x18, STATUS[7]=1, no iack_clear pulse.
5. VBASE=0xFE, source 3 acknowledged → vector_out=0x01 (wrap).
6. Assert reset_n=0 during RELEASE → next cycle iack_dtack=0, ipl_n=3'b111, CTRL=0. A register read of LEVEL[2] after writing 0x0007 returns 0x0007 with ack one cycle after as.
